// File: rtl/adder_sched_pkg.sv
// Shared types and operand-conditioning helpers for the shared-adder scheduler.
package adder_sched_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Subtract-type ops feed the inverted B operand.
  function automatic logic [DATA_W-1:0] op_b_eff(op_e op, logic [DATA_W-1:0] b);
    return ((op == OP_SUB) || (op == OP_SBC)) ? ~b : b;
  endfunction

  // ADC/SBC take the carry of the previously completed beat.
  function automatic logic op_cin(op_e op, logic carry);
    logic cin;
    case (op)
      OP_ADD:  cin = 1'b0;
      OP_SUB:  cin = 1'b1;
      default: cin = carry;
    endcase
    return cin;
  endfunction

endpackage

// File: rtl/kogge_stone_adder_pg_32_bit.sv
// Kogge-Stone parallel-prefix adder over generate/propagate pairs with carry in.
module kogge_stone_adder_pg_32_bit #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int LVLS = $clog2(N);

  logic [N-1:0] g [0:LVLS];
  logic [N-1:0] p [0:LVLS];
  logic [N:0]   c;
  int           j;

  always_comb begin
    j    = 0;
    g[0] = a & b;
    p[0] = a ^ b;
    for (int l = 0; l < LVLS; l++) begin
      for (int i = 0; i < N; i++) begin
        j = (i >= (1 << l)) ? i - (1 << l) : i;
        if (i >= (1 << l)) begin
          g[l+1][i] = g[l][i] | (p[l][i] & g[l][j]);
          p[l+1][i] = p[l][i] & p[l][j];
        end else begin
          g[l+1][i] = g[l][i];
          p[l+1][i] = p[l][i];
        end
      end
    end
    // Group terms span bits [i:0], so cin folds in once at the end.
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      c[i+1] = g[LVLS][i] | (p[LVLS][i] & cin);
    end
  end

  assign sum  = p[0] ^ c[N-1:0];
  assign cout = c[N];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: priority starts at rr_ptr+1 and wraps.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_id
);

  int   idx;
  logic found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    idx      = 0;
    found    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/adder_share_scheduler.sv
// Shares one Kogge-Stone adder among NUM_REQ requesters with round-robin
// arbitration, a lock for multi-word carry chains and a two-stage pipeline.
module adder_share_scheduler
  import adder_sched_pkg::*;
#(
  parameter  int N       = 32,
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [2*NUM_REQ-1:0] req_op,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [N*NUM_REQ-1:0] req_a,
  input  logic [N*NUM_REQ-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [N-1:0]         rsp_sum,
  output logic                 rsp_cout,
  output logic                 rsp_ovf
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   owner_q, owner_d;

  logic             s1_valid_q, s1_valid_d;
  logic [IDW-1:0]   s1_id_q, s1_id_d;
  logic [N-1:0]     s1_a_q, s1_a_d;
  logic [N-1:0]     s1_b_eff_q, s1_b_eff_d;
  op_e              s1_op_q, s1_op_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [N-1:0]     rsp_sum_q, rsp_sum_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             carry_q, carry_d;

  logic             result_adv;
  logic             s1_open;
  logic [NUM_REQ-1:0] arb_req, arb_grant, lock_grant;
  logic [IDW-1:0]   arb_id, sel_id;
  op_e              sel_op;
  logic             sel_last;
  logic             accept;
  logic [N-1:0]     add_sum;
  logic             add_cout, add_cin, add_ovf;

  assign result_adv = !rsp_valid_q || rsp_ready;
  assign s1_open    = !s1_valid_q || result_adv;

  assign arb_req = (state_q == ST_IDLE && s1_open && !rst) ? req_valid : '0;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req      (arb_req),
    .rr_ptr   (rr_ptr_q),
    .grant    (arb_grant),
    .grant_id (arb_id)
  );

  // While locked only the owner can be granted; everyone else waits.
  assign lock_grant = (state_q == ST_LOCKED && s1_open && !rst && req_valid[owner_q])
                      ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q) : '0;

  assign req_ready = arb_grant | lock_grant;
  assign accept    = |req_ready;
  assign sel_id    = (state_q == ST_LOCKED) ? owner_q : arb_id;
  assign sel_op    = op_e'(req_op[2*sel_id +: 2]);
  assign sel_last  = req_last[sel_id];

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rr_ptr_d = arb_id;
          if (!sel_last) begin
            state_d = ST_LOCKED;
            owner_d = arb_id;
          end
        end
      end
      ST_LOCKED: begin
        if (accept && sel_last) begin
          state_d  = ST_IDLE;
          rr_ptr_d = owner_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_id_d    = s1_id_q;
    s1_a_d     = s1_a_q;
    s1_b_eff_d = s1_b_eff_q;
    s1_op_d    = s1_op_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_id_d    = sel_id;
      s1_a_d     = req_a[sel_id*N +: N];
      s1_b_eff_d = op_b_eff(sel_op, req_b[sel_id*N +: N]);
      s1_op_d    = sel_op;
    end else if (result_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Cin is resolved here so a back-to-back chained beat sees the carry
  // written by the beat moving into the result register on the same edge.
  assign add_cin = op_cin(s1_op_q, carry_q);

  kogge_stone_adder_pg_32_bit #(.N(N)) u_adder (
    .a    (s1_a_q),
    .b    (s1_b_eff_q),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign add_ovf = (s1_a_q[N-1] == s1_b_eff_q[N-1]) && (add_sum[N-1] != s1_a_q[N-1]);

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_ovf_d   = rsp_ovf_q;
    carry_d     = carry_q;
    if (result_adv) begin
      rsp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        rsp_id_d   = s1_id_q;
        rsp_sum_d  = add_sum;
        rsp_cout_d = add_cout;
        rsp_ovf_d  = add_ovf;
        carry_d    = add_cout;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= IDW'(NUM_REQ - 1);
      owner_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      s1_a_q      <= '0;
      s1_b_eff_q  <= '0;
      s1_op_q     <= OP_ADD;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      s1_a_q      <= s1_a_d;
      s1_b_eff_q  <= s1_b_eff_d;
      s1_op_q     <= s1_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_ovf_q   <= rsp_ovf_d;
      carry_q     <= carry_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_adder_share_scheduler.sv
// Bench for adder_share_scheduler: directed scenarios then random traffic,
// checked against a transaction-level model of arbitration and arithmetic.
module tb_adder_share_scheduler;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ADC = 2'b10, SBC = 2'b11;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid, req_ready, req_last;
  logic [7:0]   req_op;
  logic [127:0] req_a, req_b;
  logic         rsp_valid, rsp_ready, rsp_cout, rsp_ovf;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_sum;

  always #5 clk = ~clk;

  adder_share_scheduler #(.N(32), .NUM_REQ(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_last(req_last),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
  );

  typedef struct {
    logic [1:0]  id;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  bit   m_s1, m_res, m_locked, m_carry;
  int   m_owner, m_rr;
  logic [3:0] acc;
  int   n_tests = 0, n_fail = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Arithmetic straight from the op definitions, in 33-bit integer math.
  function automatic exp_t model_op(int id, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                                    logic carry);
    logic [31:0] be;
    logic        cin;
    logic [32:0] s;
    exp_t        e;
    be  = (op == SUB || op == SBC) ? ~b : b;
    cin = (op == ADD) ? 1'b0 : (op == SUB) ? 1'b1 : carry;
    s   = {1'b0, a} + {1'b0, be} + {32'd0, cin};
    e.id   = 2'(id);
    e.sum  = s[31:0];
    e.cout = s[32];
    e.ovf  = (a[31] == be[31]) && (s[31] != a[31]);
    return e;
  endfunction

  task automatic model_reset();
    q.delete();
    m_s1 = 0; m_res = 0; m_locked = 0; m_carry = 0;
    m_owner = 0; m_rr = 3;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic set_req(int i, logic [1:0] op, logic [31:0] a, logic [31:0] b, logic last);
    req_valid[i]       = 1'b1;
    req_op[2*i +: 2]   = op;
    req_a[32*i +: 32]  = a;
    req_b[32*i +: 32]  = b;
    req_last[i]        = last;
  endtask

  task automatic set_rand(int i, logic last);
    set_req(i, 2'($urandom_range(0, 3)), rand_word(), rand_word(), last);
  endtask

  // One clock: compare DUT to model at the falling edge, then advance the model.
  task automatic cycle();
    logic [3:0] eg;
    bit         adv;
    int         g, idx;
    exp_t       e;
    @(negedge clk);
    adv = !m_res || rsp_ready;
    eg  = '0;
    g   = -1;
    if (!rst && !(m_s1 && !adv)) begin
      if (m_locked) begin
        if (req_valid[m_owner]) g = m_owner;
      end else begin
        for (int k = 1; k <= 4; k++) begin
          idx = (m_rr + k) % 4;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
    end
    if (g >= 0) eg[g] = 1'b1;
    check("req_ready", req_ready, eg);
    check("rsp_valid", rsp_valid, m_res);
    if (m_res) begin
      check("rsp_id", rsp_id, q[0].id);
      check("rsp_sum", rsp_sum, q[0].sum);
      check("rsp_cout", rsp_cout, q[0].cout);
      check("rsp_ovf", rsp_ovf, q[0].ovf);
    end
    acc = eg;
    if (rst) begin
      model_reset();
    end else begin
      if (m_res && rsp_ready) void'(q.pop_front());
      if (adv) begin
        m_res = m_s1;
        m_s1  = 0;
      end
      if (g >= 0) begin
        e = model_op(g, req_op[2*g +: 2], req_a[32*g +: 32], req_b[32*g +: 32], m_carry);
        m_carry = e.cout;
        q.push_back(e);
        m_s1 = 1;
        if (!m_locked) begin
          m_rr = g;
          if (!req_last[g]) begin
            m_locked = 1;
            m_owner  = g;
          end
        end else if (req_last[g]) begin
          m_locked = 0;
          m_rr     = m_owner;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_last = '0; req_op = '0;
    req_a = '0; req_b = '0; rsp_ready = 1'b1; acc = '0;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_rsp_cout", rsp_cout, 0);
    check("rst_rsp_ovf", rsp_ovf, 0);
    check("rst_req_ready", req_ready, 0);
    cycle();
    rst = 1'b0;
    cycle();

    // Basic ADD and two-edge latency
    set_req(0, ADD, 32'd25, 32'd75, 1'b1);
    cycle();
    req_valid = '0;
    check("add_latency", rsp_valid, 0);
    cycle();
    check("add_valid", rsp_valid, 1);
    check("add_id", rsp_id, 0);
    check("add_sum", rsp_sum, 100);
    check("add_cout", rsp_cout, 0);
    check("add_ovf", rsp_ovf, 0);

    // SUB results, back to back
    set_req(0, SUB, 32'd5, 32'd7, 1'b1);
    cycle();
    set_req(0, SUB, 32'h8000_0000, 32'd1, 1'b1);
    cycle();
    req_valid = '0;
    check("sub1_sum", rsp_sum, 32'hFFFF_FFFE);
    check("sub1_cout", rsp_cout, 0);
    check("sub1_ovf", rsp_ovf, 0);
    cycle();
    check("sub2_sum", rsp_sum, 32'h7FFF_FFFF);
    check("sub2_cout", rsp_cout, 1);
    check("sub2_ovf", rsp_ovf, 1);

    // 64-bit chain on requester 2 with requester 1 waiting
    set_req(2, ADD, 32'hFFFF_FFFF, 32'd1, 1'b0);
    cycle();
    set_req(2, ADC, 32'd0, 32'd0, 1'b1);
    set_rand(1, 1'b1);
    #1;
    check("chain_lock_ready", req_ready, 4'b0100);
    cycle();
    check("chain1_id", rsp_id, 2);
    check("chain1_sum", rsp_sum, 0);
    check("chain1_cout", rsp_cout, 1);
    req_valid[2] = 1'b0;
    #1;
    check("chain_release_ready", req_ready, 4'b0010);
    cycle();
    req_valid[1] = 1'b0;
    check("chain2_id", rsp_id, 2);
    check("chain2_sum", rsp_sum, 1);
    check("chain2_cout", rsp_cout, 0);
    cycle();

    // Backpressure: two requests, consumer stalled
    rsp_ready = 1'b0;
    set_rand(0, 1'b1);
    set_rand(3, 1'b1);
    for (int k = 0; k < 2; k++) begin
      cycle();
      req_valid &= ~acc;
    end
    set_rand(1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      #1;
      check("bp_ready_blocked", req_ready, 4'b0000);
      check("bp_rsp_held", rsp_valid, 1);
      cycle();
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      req_valid &= ~acc;
    end

    // Fairness: everyone valid, one result per cycle
    for (int i = 0; i < 4; i++) set_rand(i, 1'b1);
    for (int k = 0; k < 16; k++) begin
      cycle();
      for (int i = 0; i < 4; i++) if (acc[i]) set_rand(i, 1'b1);
      if (k >= 2) check("fair_throughput", rsp_valid, 1);
    end
    req_valid = '0;
    cycle();
    cycle();

    // Reset with stage 1 and result full while locked
    rsp_ready = 1'b0;
    set_rand(3, 1'b0);
    cycle();
    set_rand(3, 1'b0);
    cycle();
    req_valid = '0;
    check("pre_rst_full", rsp_valid, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("post_rst_rsp_valid", rsp_valid, 0);
    for (int i = 0; i < 4; i++) set_rand(i, 1'b1);
    rsp_ready = 1'b1;
    #1;
    check("post_rst_grant", req_ready, 4'b0001);
    for (int k = 0; k < 6; k++) begin
      cycle();
      req_valid &= ~acc;
    end

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      rst       = ($urandom_range(0, 149) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i] || acc[i]) begin
          set_rand(i, $urandom_range(0, 3) != 0);
          req_valid[i] = $urandom_range(0, 1) == 1;
        end
      end
      cycle();
    end
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_share_scheduler.md
# adder_share_scheduler

Shares one N-bit Kogge-Stone adder (`kogge_stone_adder_pg_32_bit`) between NUM_REQ requesters of the calculator datapath. It arbitrates round-robin and registers operands in front of the adder. It applies ADD/SUB/ADC/SBC operand conditioning and registers the result with requester ID, carry and signed overflow. A lock bit lets one requester chain multi-word (e.g. 64-bit) operations through a carry flag without interleaving.

## Interface
- N, 32, operand/result width
- NUM_REQ, 4, number of requesters (≥2); ID width IDW = $clog2(NUM_REQ)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; transfer when valid&ready
- req_op  in  2*NUM_REQ  per-requester op: 00 ADD, 01 SUB, 10 ADC, 11 SBC
- req_last  in  NUM_REQ  1 = final beat; 0 = keep grant locked after this beat
- req_a, req_b  in  N*NUM_REQ  packed operands, requester i at slice i
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumer accept
- rsp_id  out  IDW  requester ID of result
- rsp_sum  out  N  sum
- rsp_cout  out  1  adder carry out
- rsp_ovf  out  1  signed overflow

## Operation
- Op conditioning is applied at stage 1 and feeds the adder:
  - ADD: b_eff=B, Cin=0.
  - SUB: b_eff=~B, Cin=1.
  - ADC: b_eff=B, Cin=carry_q.
  - SBC: b_eff=~B, Cin=carry_q.
- Signed overflow: rsp_ovf = (A[msb]==b_eff[msb]) & (sum[msb]!=A[msb]).
- carry_q updates to adder Cout on every stage-1→result transfer. It is global and not per-requester. ADC/SBC outside a lock use the last completed beat's carry.
- Arbiter states:
  - IDLE: round-robin grant among valid requesters, priority starting at rr_ptr+1 mod NUM_REQ. On accept, rr_ptr←granted ID. If req_last=0, go to LOCKED with owner←ID.
  - LOCKED: only owner may be granted; all other req_ready=0 regardless of valid. An accepted owner beat with req_last=1 returns to IDLE and sets rr_ptr←owner. Owner valid low leaves the lock held with no timeout.
- At most one req_ready bit high per cycle, and only for a requester whose req_valid is high.
- Pipeline: stage-1 operand register (valid, id, op-conditioned A/b_eff, op) → adder (combinational) → result register.
- Results return strictly in acceptance order.

## Timing
- Reset values:
  - Outputs: req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0.
  - Internal: stage-1 valid=0, carry_q=0, state=IDLE, rr_ptr=NUM_REQ-1, so requester 0 wins first.
- req_ready is combinational from req_valid, state, rr_ptr and pipeline occupancy.
- Latency: a request accepted at edge t loads stage 1 at t; the result register loads at t+1; rsp_valid is high from t+1. Two edges total.
- Throughput: one op per cycle with rsp_ready held high.
- Backpressure:
  - result_adv = !rsp_valid | rsp_ready.
  - Stage 1 advances when result_adv.
  - Stage 1 accepts when stage-1 empty or advancing.
  - rsp_* hold stable while rsp_valid & !rsp_ready.
- Chained beats: ADC/SBC Cin is read from carry_q while the beat is in stage 1, so the previous beat's carry is always present, including back-to-back beats.
- Simultaneous events:
  - Accept and drain in the same cycle is allowed.
  - A lock release and the next grant do not occur in the same cycle. The new grant appears the cycle after release.
- rst mid-operation discards stage 1 and result contents: no response is emitted and the lock is dropped.

## Structure
- Shared package `adder_sched_pkg`: op enum (ADD, SUB, ADC, SBC), state enum (IDLE, LOCKED), and a function computing b_eff/Cin.
- Sub-module `rr_arbiter` (parameter NUM_REQ): inputs req mask and rr_ptr; outputs one-hot grant and ID.
- One instance of `kogge_stone_adder_pg_32_bit` with N=32.

## Test plan
- Basic ADD: req0 ADD A=25 B=75, last=1 → two edges later rsp_valid=1, id=0, sum=100, cout=0, ovf=0.
- SUB results:
  - 5−7 → sum=0xFFFFFFFE, cout=0, ovf=0.
  - 0x80000000−1 → sum=0x7FFFFFFF, cout=1, ovf=1.
- Fairness: all four requesters valid continuously, rsp_ready=1 → rsp_id sequence 0,1,2,3,0,… at one result per cycle.
- 64-bit chain: req2 ADD 0xFFFFFFFF+1, last=0, then ADC 0+0, last=1; req1 valid throughout → sums 0 (cout=1) then 1, and req1 receives no ready until the cycle after req2's last beat.
- Backpressure: two requests, rsp_ready=0 for 3 cycles → first result held stable, req_ready=0 once stage 1 is full; after release both results arrive in order on consecutive cycles.
- Reset mid-op: rst high with stage 1 and result full and LOCKED → next cycle rsp_valid=0, state IDLE, and the first grant goes to requester 0.
